approx_series_engine: RTL and testbench

Parametrised iterative fixed-point series evaluator. It succeeds the fixed 16-bit approximation top and merges controller and datapath into one block. It computes exp(x) or ln(1+x) as a truncated Taylor series with a run-time iteration count. A single shared multiplier and a compile-time reciprocal table replace division, and the result is held under a valid/ack output handshake.

---
 rtl/approx_series_engine.sv | 163 ++++++++++++++++
 tb/tb_approx_series_engine.sv | 124 ++++++++++++
 2 files changed

// File: rtl/approx_series_engine.sv
// Iterative Taylor-series evaluator for exp(x) / ln(1+x) with one shared multiplier.
// Build option: APPROX_ROUND_EN selects round-half-up products instead of floor.
module approx_series_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int IT_W  = 4,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [IT_W-1:0]  nIt_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);
  localparam int AW = WIDTH + GUARD;
  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_MUL_X = 3'd2;
  localparam logic [2:0] S_MUL_R = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic signed [WIDTH-1:0] ONE_W = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [AW-1:0]    ONE_A = {{(AW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    MAX_A = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0]    MIN_A = {1'b1, {(AW-1){1'b0}}};

  logic [2:0]              state_q, state_d;
  logic signed [WIDTH-1:0] x_q, p_q, t_q, y_q;
  logic signed [AW-1:0]    acc_q;
  logic                    mode_q, valid_q, busy_q, ovf_q;
  logic [IT_W-1:0]         nit_q, n_q;

  // Reciprocal table R(n) = round(2^FRAC / n); entry 0 is never selected.
  logic [WIDTH-1:0] rtab [2**IT_W];
  for (genvar gi = 0; gi < 2**IT_W; gi++) begin : g_rtab
    localparam int DIV = (gi == 0) ? 1 : gi;
    localparam int RV  = (gi == 0) ? 0 : (((1 << FRAC) + DIV / 2) / DIV);
    assign rtab[gi] = WIDTH'(RV);
  end

  logic signed [WIDTH-1:0] mul_b, mul_res;
  logic signed [PW-1:0]    prod;
  logic signed [PW:0]      prod_x, sh;
  logic                    mul_ovf;

  always_comb begin
    mul_b  = (state_q == S_MUL_R) ? $signed(rtab[n_q]) : x_q;
    prod   = p_q * mul_b;
`ifdef APPROX_ROUND_EN
    prod_x = {prod[PW-1], prod} + $signed({{(PW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
`else
    prod_x = {prod[PW-1], prod};
`endif
    sh      = prod_x >>> FRAC;
    mul_ovf = !((&sh[PW:WIDTH-1]) || !(|sh[PW:WIDTH-1]));
    mul_res = mul_ovf ? (sh[PW] ? MIN_W : MAX_W) : sh[WIDTH-1:0];
  end

  // ln alternates sign: even-numbered terms subtract.
  logic signed [AW:0]      sum;
  logic signed [AW-1:0]    acc_res;
  logic                    acc_ovf, y_ovf;
  logic signed [WIDTH-1:0] y_res;

  always_comb begin
    if (mode_q && !n_q[0])
      sum = {acc_q[AW-1], acc_q} - {{(AW+1-WIDTH){t_q[WIDTH-1]}}, t_q};
    else
      sum = {acc_q[AW-1], acc_q} + {{(AW+1-WIDTH){t_q[WIDTH-1]}}, t_q};
    acc_ovf = sum[AW] ^ sum[AW-1];
    acc_res = acc_ovf ? (sum[AW] ? MIN_A : MAX_A) : sum[AW-1:0];
    y_ovf   = !((&acc_q[AW-1:WIDTH-1]) || !(|acc_q[AW-1:WIDTH-1]));
    y_res   = y_ovf ? (acc_q[AW-1] ? MIN_W : MAX_W) : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_INIT;
      S_INIT:  state_d = (nit_q == '0) ? S_DONE : S_MUL_X;
      S_MUL_X: state_d = S_MUL_R;
      S_MUL_R: state_d = S_ACC;
      S_ACC:   state_d = (n_q == nit_q) ? S_DONE : S_MUL_X;
      S_DONE:  if (valid_q && ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      p_q     <= '0;
      t_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      nit_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_q == S_INIT) || (state_q == S_MUL_X) ||
                 (state_q == S_MUL_R) || (state_q == S_ACC);
      case (state_q)
        S_IDLE: if (start_i) begin
          x_q    <= x_i;
          mode_q <= mode_i;
          nit_q  <= nIt_i;
          ovf_q  <= 1'b0;
        end
        S_INIT: begin
          p_q   <= ONE_W;
          n_q   <= IT_W'(1);
          acc_q <= mode_q ? '0 : ONE_A;
        end
        S_MUL_X: begin
          p_q   <= mul_res;
          ovf_q <= ovf_q | mul_ovf;
        end
        S_MUL_R: begin
          t_q   <= mul_res;
          if (!mode_q) p_q <= mul_res;
          ovf_q <= ovf_q | mul_ovf;
        end
        S_ACC: begin
          acc_q <= acc_res;
          ovf_q <= ovf_q | acc_ovf;
          n_q   <= n_q + IT_W'(1);
        end
        S_DONE: begin
          // First DONE cycle publishes the result; ack only counts once it is visible.
          if (!valid_q) begin
            valid_q <= 1'b1;
            y_q     <= y_res;
            ovf_q   <= ovf_q | y_ovf;
          end else if (ack_i) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign y_o     = y_q;
  assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_approx_series_engine.sv
// Directed bench for approx_series_engine (expected values hand-computed).
module tb_approx_series_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, mode_i, ack_i;
  logic [15:0] x_i;
  logic [3:0]  nIt_i;
  logic        busy_o, valid_o, ovf_o;
  logic [15:0] y_o;

  int passed = 0;
  int total  = 0;

`ifdef APPROX_ROUND_EN
  localparam logic [15:0] EXP1 = 16'd11094;
  localparam logic [15:0] LN05 = 16'd1707;
`else
  localparam logic [15:0] EXP1 = 16'd11092;
  localparam logic [15:0] LN05 = 16'd1706;
`endif

  approx_series_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .x_i(x_i),
    .nIt_i(nIt_i), .ack_i(ack_i), .busy_o(busy_o), .valid_o(valid_o),
    .y_o(y_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic m, input logic [15:0] x, input logic [3:0] n,
                     input logic [15:0] ey, input logic eo, input string tag);
    int k;
    logic bad_busy;
    @(negedge clk);
    mode_i = m; x_i = x; nIt_i = n; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0; bad_busy = 1'b0;
    while (valid_o !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (valid_o !== 1'b1 && busy_o !== 1'b1) bad_busy = 1'b1;
      if (valid_o === 1'b1 && busy_o !== 1'b0) bad_busy = 1'b1;
    end
    chk({tag, "_lat"}, k, 2 + 3 * n);
    chk({tag, "_busy"}, {31'd0, bad_busy}, 0);
    chk({tag, "_y"}, {16'd0, y_o}, {16'd0, ey});
    chk({tag, "_ovf"}, {31'd0, ovf_o}, {31'd0, eo});
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    chk({tag, "_ack_valid"}, {31'd0, valid_o}, 0);
  endtask

  initial begin
    logic stable_bad;
    rst = 1'b0; start_i = 1'b0; mode_i = 1'b0; ack_i = 1'b0; x_i = '0; nIt_i = '0;
    #12;
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_y", {16'd0, y_o}, 0);
    chk("rst_ovf", {31'd0, ovf_o}, 0);
    @(negedge clk); rst = 1'b1;

    run(1'b0, 16'd0, 4'd5, 16'd4096, 1'b0, "exp_x0");   do_ack("exp_x0");
    run(1'b0, 16'd4096, 4'd4, EXP1, 1'b0, "exp_x1");     do_ack("exp_x1");
    run(1'b1, 16'd2048, 4'd3, LN05, 1'b0, "ln_half");    do_ack("ln_half");
    run(1'b0, 16'hF000, 4'd2, 16'd2048, 1'b0, "exp_m1"); do_ack("exp_m1");
    run(1'b1, 16'd1234, 4'd0, 16'd0, 1'b0, "ln_n0");     do_ack("ln_n0");
    run(1'b0, 16'h7FFF, 4'd15, 16'h7FFF, 1'b1, "exp_sat");

    // Result must hold while start pulses and operands change without ack.
    stable_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_i = i[0]; x_i = 16'(i * 977); nIt_i = 4'(i); mode_i = i[1];
      @(posedge clk); #1;
      if (valid_o !== 1'b1 || y_o !== 16'h7FFF || ovf_o !== 1'b1 || busy_o !== 1'b0)
        stable_bad = 1'b1;
    end
    chk("hold_stable", {31'd0, stable_bad}, 0);

    @(negedge clk);
    ack_i = 1'b1; start_i = 1'b1; mode_i = 1'b0; x_i = 16'd0; nIt_i = 4'd1;
    @(posedge clk); #1;
    ack_i = 1'b0; start_i = 1'b0;
    chk("ackstart_valid", {31'd0, valid_o}, 0);
    chk("ackstart_busy0", {31'd0, busy_o}, 0);
    @(posedge clk); #1;
    chk("ackstart_busy1", {31'd0, busy_o}, 0);

    run(1'b0, 16'd0, 4'd1, 16'd4096, 1'b0, "ovf_clear"); do_ack("ovf_clear");

    // Asynchronous reset while in MUL_R.
    @(negedge clk);
    mode_i = 1'b0; x_i = 16'd4096; nIt_i = 4'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre_rst_busy", {31'd0, busy_o}, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 0);
    chk("arst_valid", {31'd0, valid_o}, 0);
    chk("arst_y", {16'd0, y_o}, 0);
    chk("arst_ovf", {31'd0, ovf_o}, 0);
    @(negedge clk); rst = 1'b1;
    run(1'b0, 16'd0, 4'd0, 16'd4096, 1'b0, "post_rst"); do_ack("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
